press_pulse_shaper: RTL and testbench

- Output-side counterpart to the push-button debouncer. The debouncer enforces a minimum dwell on a noisy input; this block enforces a minimum dwell on an output.
- Consumes single-cycle press events (debouncer button_out) and replays each one as a clean, human-visible pulse: HOLD_CYCLES high, then GAP_CYCLES low.
- Presses arriving while a pulse is in flight are queued in a saturating counter and replayed in order. Typical load: LED, buzzer, or downstream handshake line.

---
 rtl/press_pulse_shaper.sv | 110 +++++++++++
 tb/tb_press_pulse_shaper.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/press_pulse_shaper.sv
// Replays single-cycle press events as HOLD_CYCLES-high / GAP_CYCLES-low pulses,
// queueing presses that arrive mid-pulse in a saturating pending counter.
module press_pulse_shaper #(
  parameter int HOLD_CYCLES = 1000,
  parameter int GAP_CYCLES  = 1000,
  parameter int CNT_W       = 16,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic              clr_ovf,
  output logic              pulse_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0]  HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              pulse_q, busy_q;
  logic              accept, drop;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    accept  = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pulse_in) begin
          state_d = HIGH;
          timer_d = HOLD_LD;
        end
      end
      HIGH: begin
        accept = pulse_in;
        if (timer_q == '0) begin
          state_d = LOW;
          timer_d = GAP_LD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      LOW: begin
        if (timer_q == '0) begin
          // A press landing on the final gap cycle either restarts directly or
          // cancels against the queued event being consumed.
          if (pend_q != '0) begin
            state_d = HIGH;
            timer_d = HOLD_LD;
            if (!pulse_in) pend_d = pend_q - 1'b1;
          end else if (pulse_in) begin
            state_d = HIGH;
            timer_d = HOLD_LD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
          accept  = pulse_in;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    if (accept) begin
      if (pend_q == PEND_MAX) drop = 1'b1;
      else                    pend_d = pend_q + 1'b1;
    end

    ovf_d = drop | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      pulse_q <= (state_d == HIGH);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_press_pulse_shaper.sv
// Bench for press_pulse_shaper: period-position reference model checked every
// cycle, plus directed scenarios with hand-computed cycle expectations.
module tb_press_pulse_shaper;

  localparam int H      = 4;
  localparam int G      = 3;
  localparam int PEND_W = 2;
  localparam int PMAX   = (1 << PEND_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pulse_in = 1'b0;
  logic              clr_ovf = 1'b0;
  logic              pulse_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  press_pulse_shaper #(
    .HOLD_CYCLES(H),
    .GAP_CYCLES (G),
    .CNT_W      (8),
    .PEND_W     (PEND_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .clr_ovf  (clr_ovf),
    .pulse_out(pulse_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference: position within the current H+G output period.
  bit m_active = 1'b0;
  int m_pos    = 0;
  int m_pend   = 0;
  bit m_ovf    = 1'b0;

  always @(posedge clk or posedge rst) begin
    bit drop;
    if (rst) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_pend   = 0;
      m_ovf    = 1'b0;
    end else begin
      drop = 1'b0;
      if (!m_active) begin
        if (pulse_in) begin
          m_active = 1'b1;
          m_pos    = 0;
        end
      end else if (m_pos == H + G - 1) begin
        if (m_pend > 0) begin
          m_pos = 0;
          if (!pulse_in) m_pend = m_pend - 1;
        end else if (pulse_in) begin
          m_pos = 0;
        end else begin
          m_active = 1'b0;
        end
      end else begin
        m_pos = m_pos + 1;
        if (pulse_in) begin
          if (m_pend == PMAX) drop = 1'b1;
          else                m_pend = m_pend + 1;
        end
      end
      if (drop)         m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pulse_out", int'(pulse_out), int'(m_active && m_pos < H));
      check("model_busy",      int'(busy),      int'(m_active));
      check("model_pending",   int'(pending),   m_pend);
      check("model_overflow",  int'(overflow),  int'(m_ovf));
    end
  end

  task automatic tick(input bit in, input bit clr);
    pulse_in = in;
    clr_ovf  = clr;
    @(posedge clk);
    #1;
    cyc++;
    pulse_in = 1'b0;
    clr_ovf  = 1'b0;
  endtask

  task automatic do_reset();
    pulse_in = 1'b0;
    clr_ovf  = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick(1'b0, 1'b0);
  endtask

  initial begin
    // Single press at cycle 10
    do_reset();
    chk_en = 1'b1;
    check("reset_pulse_out", int'(pulse_out), 0);
    check("reset_busy",      int'(busy),      0);
    check("reset_pending",   int'(pending),   0);
    check("reset_overflow",  int'(overflow),  0);
    run_to(10);
    tick(1'b1, 1'b0);
    while (cyc <= 20) begin
      check("single_pulse_out", int'(pulse_out), int'(cyc >= 11 && cyc <= 14));
      check("single_busy",      int'(busy),      int'(cyc >= 11 && cyc <= 17));
      check("single_pending",   int'(pending),   0);
      tick(1'b0, 1'b0);
    end

    // Queued presses at 10, 12, 13
    do_reset();
    run_to(10);
    while (cyc <= 34) begin
      tick(cyc == 10 || cyc == 12 || cyc == 13, 1'b0);
      check("queue_pulse_out", int'(pulse_out),
            int'((cyc >= 11 && cyc <= 14) || (cyc >= 18 && cyc <= 21) || (cyc >= 25 && cyc <= 28)));
      check("queue_busy", int'(busy), int'(cyc >= 11 && cyc <= 31));
      check("queue_pending", int'(pending),
            (cyc == 13) ? 1 : (cyc >= 14 && cyc <= 17) ? 2 : (cyc >= 18 && cyc <= 24) ? 1 : 0);
    end

    // Saturation, then clear colliding with a drop, then clear alone
    do_reset();
    run_to(10);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    while (cyc <= 15) tick(1'b1, 1'b0);
    check("sat_pending",  int'(pending),  3);
    check("sat_overflow", int'(overflow), 1);
    tick(1'b1, 1'b1);
    check("clr_vs_drop_overflow", int'(overflow), 1);
    tick(1'b0, 1'b1);
    check("clr_alone_overflow", int'(overflow), 0);
    check("clr_alone_pending",  int'(pending),  2);

    // Five presses while busy: exactly four output pulses
    do_reset();
    begin
      int rises = 0;
      bit prev  = 1'b0;
      run_to(10);
      while (cyc <= 45) begin
        tick(cyc == 10 || (cyc >= 12 && cyc <= 16), 1'b0);
        if (pulse_out && !prev) begin
          rises++;
          check("sat_rise_cycle", cyc, 11 + 7 * (rises - 1));
        end
        prev = pulse_out;
        if (cyc >= 16) check("sat_overflow_sticky", int'(overflow), 1);
      end
      check("sat_pulse_count", rises, 4);
    end

    // Restart on the final gap cycle
    do_reset();
    run_to(10);
    while (cyc <= 24) begin
      tick(cyc == 10 || cyc == 17, 1'b0);
      check("restart_pulse_out", int'(pulse_out),
            int'((cyc >= 11 && cyc <= 14) || (cyc >= 18 && cyc <= 21)));
      check("restart_pending",  int'(pending),  0);
      check("restart_overflow", int'(overflow), 0);
    end

    // Asynchronous reset mid-HIGH
    do_reset();
    run_to(10);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("pre_areset_pulse_out", int'(pulse_out), 1);
    #2;
    rst = 1'b1;
    #1;
    check("areset_pulse_out", int'(pulse_out), 0);
    check("areset_busy",      int'(busy),      0);
    check("areset_pending",   int'(pending),   0);
    check("areset_overflow",  int'(overflow),  0);
    @(posedge clk);
    #1;
    cyc++;
    tick(1'b0, 1'b0);
    rst = 1'b0;
    run_to(20);
    tick(1'b1, 1'b0);
    while (cyc <= 26) begin
      check("post_areset_pulse_out", int'(pulse_out), int'(cyc >= 21 && cyc <= 24));
      tick(1'b0, 1'b0);
    end

    // Randomised traffic with varying press density
    do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      int dens = $urandom_range(1, 12);
      for (int i = 0; i < 200; i++)
        tick($urandom_range(0, dens) == 0, $urandom_range(0, 24) == 0);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
